// File: rtl/inta_sequencer.sv
// Interrupt acknowledge initiator: drives registered active-low INTA pulses and captures the PIC vector.
// Optional macro INTA_8080_EN adds the 3-pulse 8080 CALL sequence (mode8080/addr). int_req is the PIC INT pin.
module inta_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        ien,
  output logic        inta,
  input  logic [7:0]  D,
  output logic [7:0]  vec,
  output logic        vec_valid,
  input  logic        vec_ack,
  output logic        busy
`ifdef INTA_8080_EN
  ,
  input  logic        mode8080,
  output logic [15:0] addr
`endif
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    G1,
    P2,
`ifdef INTA_8080_EN
    G2,
    P3,
`endif
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last;
  logic             inta_nxt;
  logic             cap_vec;
  logic [7:0]       vec_src;
`ifdef INTA_8080_EN
  logic             mode, mode_nxt;
  logic             cap_lo, cap_hi;
`endif

  assign last      = (cnt == '0);
  assign vec_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = last ? cnt : cnt - CNT_ONE;
    cap_vec   = 1'b0;
    vec_src   = D;
`ifdef INTA_8080_EN
    mode_nxt  = mode;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (int_req && ien) begin
          state_nxt = P1;
          cnt_nxt   = PULSE_LD;
`ifdef INTA_8080_EN
          mode_nxt  = mode8080;
`endif
        end
      end
      P1: begin
        if (last) begin
          state_nxt = G1;
          cnt_nxt   = GAP_LD;
        end
      end
      G1: begin
        if (last) begin
          state_nxt = P2;
          cnt_nxt   = PULSE_LD;
        end
      end
      P2: begin
        if (last) begin
`ifdef INTA_8080_EN
          if (mode) begin
            state_nxt = G2;
            cnt_nxt   = GAP_LD;
            cap_lo    = 1'b1;
          end else begin
            state_nxt = DONE;
            cap_vec   = 1'b1;
          end
`else
          state_nxt = DONE;
          cap_vec   = 1'b1;
`endif
        end
      end
`ifdef INTA_8080_EN
      G2: begin
        if (last) begin
          state_nxt = P3;
          cnt_nxt   = PULSE_LD;
        end
      end
      P3: begin
        // Vector is the low CALL-target byte captured during P2.
        if (last) begin
          state_nxt = DONE;
          cap_hi    = 1'b1;
          cap_vec   = 1'b1;
          vec_src   = addr[7:0];
        end
      end
`endif
      DONE: begin
        if (vec_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // inta is registered from the next state so it changes exactly on phase edges.
    inta_nxt = 1'b1;
    case (state_nxt)
      P1, P2: inta_nxt = 1'b0;
`ifdef INTA_8080_EN
      P3:     inta_nxt = 1'b0;
`endif
      default: inta_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      inta  <= 1'b1;
      vec   <= 8'h00;
`ifdef INTA_8080_EN
      mode  <= 1'b0;
      addr  <= 16'h0000;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      inta  <= inta_nxt;
      if (cap_vec) vec <= vec_src;
`ifdef INTA_8080_EN
      mode  <= mode_nxt;
      if (cap_lo) addr[7:0]  <= D;
      if (cap_hi) addr[15:8] <= D;
`endif
    end
  end

endmodule
